// File: rtl/isa_pkg.sv
// Shared ISA decode definitions for the multicycle control unit.
package isa_pkg;

    localparam int unsigned KEY_W  = 7;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned RES_W  = 2;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_RALU, CLS_IALU, CLS_STORE, CLS_LOAD,
        CLS_BRANCH, CLS_JALR, CLS_JAL, CLS_LUI
    } inst_class_t;

    typedef enum logic [1:0] {
        EXK_SINGLE, EXK_MUL, EXK_DIV
    } exec_kind_t;

    // Decode key is {opcode, dir_mode, inst_type}
    localparam logic [KEY_W-1:0]  KEY_LUI   = 7'b000_10_00;
    localparam logic [KEY_W-1:0]  KEY_JAL   = 7'b000_10_10;
    localparam logic [MODE_W-1:0] MODE_REG  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_IMM  = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_ALU  = 2'b00;
    localparam logic [TYPE_W-1:0] TYPE_MEM  = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_CTL  = 2'b10;

    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_MUL  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_DIV  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_REMU = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SLL  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SRL  = 3'b110;

    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

    // Classify a decode key; unknown keys map to CLS_ILLEGAL
    function automatic inst_class_t isa_class(input logic [KEY_W-1:0] key);
        logic [OP_W-1:0]   op;
        logic [MODE_W-1:0] mode;
        logic [TYPE_W-1:0] typ;
        inst_class_t       cls;
        op   = key[6:4];
        mode = key[3:2];
        typ  = key[1:0];
        cls  = CLS_ILLEGAL;
        if (mode == MODE_REG && typ == TYPE_ALU) begin
            if (op <= 3'd4) cls = CLS_RALU;
        end else if (mode == MODE_IMM && typ == TYPE_ALU) begin
            if (op <= 3'd2) cls = CLS_IALU;
        end else if (mode == MODE_IMM && typ == TYPE_MEM) begin
            if (op == 3'd0)      cls = CLS_STORE;
            else if (op <= 3'd3) cls = CLS_LOAD;
        end else if (mode == MODE_IMM && typ == TYPE_CTL) begin
            if (op == 3'd0)      cls = CLS_JALR;
            else if (op <= 3'd4) cls = CLS_BRANCH;
        end else if (key == KEY_LUI) begin
            cls = CLS_LUI;
        end else if (key == KEY_JAL) begin
            cls = CLS_JAL;
        end
        return cls;
    endfunction

    // ALU operation for a decode key
    function automatic logic [ALU_W-1:0] isa_alu_ctrl(input logic [KEY_W-1:0] key);
        logic [OP_W-1:0]  op;
        logic [ALU_W-1:0] ctrl;
        op   = key[6:4];
        ctrl = ALU_ADD;
        case (isa_class(key))
            CLS_RALU:   ctrl = op;
            CLS_IALU:   ctrl = (op == 3'd1) ? ALU_SLL : (op == 3'd2) ? ALU_SRL : ALU_ADD;
            CLS_BRANCH: ctrl = ALU_SUB;
            CLS_LUI:    ctrl = ALU_SLL;
            default:    ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    // Second ALU operand: register for R-type and compares, immediate otherwise
    function automatic logic isa_alu_src(input inst_class_t cls);
        return !(cls == CLS_RALU || cls == CLS_BRANCH || cls == CLS_ILLEGAL);
    endfunction

    // Which EXEC length class a key belongs to
    function automatic exec_kind_t isa_exec_kind(input logic [KEY_W-1:0] key);
        exec_kind_t kind;
        kind = EXK_SINGLE;
        if (isa_class(key) == CLS_RALU) begin
            if (key[6:4] == ALU_MUL) kind = EXK_MUL;
            else if (key[6:4] == ALU_DIV || key[6:4] == ALU_REMU) kind = EXK_DIV;
        end
        return kind;
    endfunction

endpackage

// File: rtl/exec_cycle_counter.sv
// Loadable down-counter timing the EXEC phase; done when the count reaches zero.
module exec_cycle_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    // Load takes priority; otherwise count down while enabled and non-zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch, decode, variable-length execute, memory, writeback.
module multicycle_control_unit
    import isa_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       inst_type,
    input  logic [1:0]       dir_mode,
    input  logic [2:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic [1:0]       result_source,
    output logic             alu_source,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned EXEC_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned EXEC_CW  = (EXEC_MAX > 1) ? $clog2(EXEC_MAX) : 1;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d, key_in;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               illegal_q, illegal_d;
    inst_class_t        cls_in, cls_q;
    exec_kind_t         kind_in;
    logic               cnt_load, cnt_en, cnt_done, retire;
    logic [EXEC_CW-1:0] cnt_load_val;

    assign key_in  = {opcode, dir_mode, inst_type};
    assign cls_in  = isa_class(key_in);
    assign kind_in = isa_exec_kind(key_in);
    assign cls_q   = isa_class(key_q);

    exec_cycle_counter #(.W(EXEC_CW)) u_exec_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_val),
        .en         (cnt_en),
        .done       (cnt_done)
    );

    // Next state, strobes and counter control from state and latched key
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        illegal_d     = illegal_q;
        instret_d     = instret_q;
        retire        = 1'b0;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;
        cnt_load_val  = '0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        result_source = RES_ALU;
        alu_source    = 1'b0;
        alu_control   = ALU_ADD;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                key_d = key_in;
                if (cls_in == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    cnt_load = 1'b1;
                    case (kind_in)
                        EXK_MUL: cnt_load_val = EXEC_CW'(MUL_CYCLES - 1);
                        EXK_DIV: cnt_load_val = EXEC_CW'(DIV_CYCLES - 1);
                        default: cnt_load_val = '0;
                    endcase
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_source  = isa_alu_src(cls_q);
                alu_control = isa_alu_ctrl(key_q);
                cnt_en      = 1'b1;
                if (cnt_done) begin
                    case (cls_q)
                        CLS_LOAD, CLS_STORE: state_d = MEM;
                        CLS_BRANCH: begin
                            branch  = 1'b1;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                        default: state_d = WB;
                    endcase
                end
            end
            MEM: begin
                dmem_req  = 1'b1;
                mem_write = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                jump      = (cls_q == CLS_JAL || cls_q == CLS_JALR);
                if (cls_q == CLS_LOAD)                          result_source = RES_MEM;
                else if (cls_q == CLS_JAL || cls_q == CLS_JALR) result_source = RES_PC4;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase

        if (retire) instret_d = instret_q + CNT_W'(1);
    end

    // State, latched key, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            key_q     <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-instruction cycle traces built from the ISA rules, checked every cycle.
module tb_multicycle_control_unit;

    localparam int MUL_C = 3;
    localparam int DIV_C = 16;
    localparam int CW    = 4;

    localparam int K_ILL = 0, K_WB = 1, K_LOAD = 2, K_SB = 3, K_BR = 4, K_JMP = 5;

    localparam logic [6:0] KEY_ADD  = 7'b000_00_00;
    localparam logic [6:0] KEY_SUB  = 7'b001_00_00;
    localparam logic [6:0] KEY_MUL  = 7'b010_00_00;
    localparam logic [6:0] KEY_DIV  = 7'b011_00_00;
    localparam logic [6:0] KEY_REMU = 7'b100_00_00;
    localparam logic [6:0] KEY_ADDI = 7'b000_01_00;
    localparam logic [6:0] KEY_SLL  = 7'b001_01_00;
    localparam logic [6:0] KEY_SLR  = 7'b010_01_00;
    localparam logic [6:0] KEY_SB   = 7'b000_01_01;
    localparam logic [6:0] KEY_LBU  = 7'b001_01_01;
    localparam logic [6:0] KEY_LH   = 7'b011_01_01;
    localparam logic [6:0] KEY_JALR = 7'b000_01_10;
    localparam logic [6:0] KEY_BEQ  = 7'b001_01_10;
    localparam logic [6:0] KEY_BLT  = 7'b100_01_10;
    localparam logic [6:0] KEY_LUI  = 7'b000_10_00;
    localparam logic [6:0] KEY_JAL  = 7'b000_10_10;
    localparam logic [6:0] KEY_BAD  = 7'b111_00_00;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    inst_type = '0;
    logic [1:0]    dir_mode = '0;
    logic [2:0]    opcode = '0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write;
    logic          branch, jump, alu_source, illegal;
    logic [1:0]    result_source;
    logic [2:0]    alu_control;
    logic [CW-1:0] instret;

    multicycle_control_unit #(
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_type     (inst_type),
        .dir_mode      (dir_mode),
        .opcode        (opcode),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .mem_write     (mem_write),
        .branch        (branch),
        .jump          (jump),
        .result_source (result_source),
        .alu_source    (alu_source),
        .alu_control   (alu_control),
        .illegal       (illegal),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    // One cycle of a trace: inputs to apply and outputs required
    typedef struct packed {
        logic       imem_rdy;
        logic       dmem_rdy;
        logic       imem_req;
        logic       dmem_req;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] res;
        logic       alu_chk;
        logic       alu_src;
        logic [2:0] alu_ctl;
        logic       illegal;
        logic       retire;
    } cyc_t;

    cyc_t        trace[$];
    cyc_t        exp_cur = '0;
    logic        chk_en = 1'b0;
    logic [31:0] exp_instret = '0;
    int          retired = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int obs_cycles, obs_reg, obs_reg_at, obs_dmem, obs_div, obs_branch, obs_branch_at;
    int obs_pc, obs_memw, obs_jump, obs_resmem, obs_imem;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction table: behaviour class, EXEC length, ALU op and operand source
    task automatic model_info(input logic [6:0] key, output int kind, output int n,
                              output logic [2:0] alu, output logic src);
        kind = K_WB; n = 1; alu = 3'b000; src = 1'b1;
        case (key)
            KEY_ADD:  begin alu = 3'b000; src = 1'b0; end
            KEY_SUB:  begin alu = 3'b001; src = 1'b0; end
            KEY_MUL:  begin alu = 3'b010; src = 1'b0; n = MUL_C; end
            KEY_DIV:  begin alu = 3'b011; src = 1'b0; n = DIV_C; end
            KEY_REMU: begin alu = 3'b100; src = 1'b0; n = DIV_C; end
            KEY_ADDI: alu = 3'b000;
            KEY_SLL:  alu = 3'b101;
            KEY_SLR:  alu = 3'b110;
            KEY_SB:   kind = K_SB;
            KEY_LBU, 7'b010_01_01, KEY_LH: kind = K_LOAD;
            KEY_JALR: kind = K_JMP;
            KEY_BEQ, 7'b010_01_10, 7'b011_01_10, KEY_BLT: begin
                kind = K_BR; alu = 3'b001; src = 1'b0;
            end
            KEY_LUI:  alu = 3'b101;
            KEY_JAL:  kind = K_JMP;
            default:  kind = K_ILL;
        endcase
    endtask

    // Build the full cycle trace for one instruction with given memory waits
    task automatic build(input logic [6:0] key, input int iw, input int dw);
        int kind, n;
        logic [2:0] alu;
        logic src;
        cyc_t e;
        model_info(key, kind, n, alu, src);
        trace.delete();
        for (int i = 0; i < iw; i++) begin
            e = '0; e.imem_req = 1'b1; trace.push_back(e);
        end
        e = '0; e.imem_rdy = 1'b1; e.imem_req = 1'b1; e.ir_write = 1'b1; trace.push_back(e);
        e = '0; e.dmem_rdy = 1'b1; trace.push_back(e);
        if (kind == K_ILL) return;
        for (int i = 0; i < n; i++) begin
            e = '0; e.imem_rdy = 1'b1; e.dmem_rdy = 1'b1;
            e.alu_chk = 1'b1; e.alu_src = src; e.alu_ctl = alu;
            if (i == n - 1 && kind == K_BR) begin e.branch = 1'b1; e.retire = 1'b1; end
            trace.push_back(e);
        end
        if (kind == K_BR) return;
        if (kind == K_LOAD || kind == K_SB) begin
            for (int i = 0; i <= dw; i++) begin
                e = '0; e.dmem_req = 1'b1; e.mem_write = (kind == K_SB); e.dmem_rdy = (i == dw);
                if (i == dw && kind == K_SB) begin e.pc_write = 1'b1; e.retire = 1'b1; end
                trace.push_back(e);
            end
        end
        if (kind == K_SB) return;
        e = '0; e.imem_rdy = 1'b1; e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        e.jump = (kind == K_JMP);
        e.res  = (kind == K_LOAD) ? 2'b01 : (kind == K_JMP) ? 2'b10 : 2'b00;
        trace.push_back(e);
    endtask

    task automatic build_halt(input int n);
        cyc_t e;
        trace.delete();
        for (int i = 0; i < n; i++) begin
            e = '0; e.imem_rdy = 1'b1; e.dmem_rdy = i[0]; e.illegal = 1'b1; trace.push_back(e);
        end
    endtask

    // Apply up to lim trace entries, one per cycle
    task automatic run_trace(input int lim);
        obs_cycles = 0; obs_reg = 0; obs_reg_at = 0; obs_dmem = 0; obs_div = 0;
        obs_branch = 0; obs_branch_at = 0; obs_pc = 0; obs_memw = 0; obs_jump = 0;
        obs_resmem = 0; obs_imem = 0;
        for (int i = 0; i < trace.size() && i < lim; i++) begin
            @(negedge clk);
            imem_ready  = trace[i].imem_rdy;
            dmem_ready  = trace[i].dmem_rdy;
            exp_cur     = trace[i];
            exp_instret = 32'(retired % (1 << CW));
            if (trace[i].retire) retired++;
            chk_en = 1'b1;
        end
        #3;
        chk_en = 1'b0;
    endtask

    task automatic set_inst(input logic [6:0] key);
        {opcode, dir_mode, inst_type} = key;
    endtask

    task automatic run_inst(input logic [6:0] key, input int iw, input int dw);
        set_inst(key);
        build(key, iw, dw);
        run_trace(1000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        chk_en = 1'b0; reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        retired = 0;
    endtask

    // Per-cycle comparison of every output against the current trace entry
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            obs_cycles++;
            chk("imem_req",  32'(imem_req),  32'(exp_cur.imem_req));
            chk("dmem_req",  32'(dmem_req),  32'(exp_cur.dmem_req));
            chk("ir_write",  32'(ir_write),  32'(exp_cur.ir_write));
            chk("pc_write",  32'(pc_write),  32'(exp_cur.pc_write));
            chk("reg_write", 32'(reg_write), 32'(exp_cur.reg_write));
            chk("mem_write", 32'(mem_write), 32'(exp_cur.mem_write));
            chk("branch",    32'(branch),    32'(exp_cur.branch));
            chk("jump",      32'(jump),      32'(exp_cur.jump));
            chk("illegal",   32'(illegal),   32'(exp_cur.illegal));
            chk("instret",   32'(instret),   exp_instret);
            chk("wr_excl",   32'(mem_write & reg_write), 32'd0);
            if (exp_cur.reg_write) chk("result_source", 32'(result_source), 32'(exp_cur.res));
            if (exp_cur.alu_chk) begin
                chk("alu_source",  32'(alu_source),  32'(exp_cur.alu_src));
                chk("alu_control", 32'(alu_control), 32'(exp_cur.alu_ctl));
            end
            if (reg_write) begin obs_reg++; obs_reg_at = obs_cycles; end
            if (branch) begin obs_branch++; obs_branch_at = obs_cycles; end
            if (dmem_req) obs_dmem++;
            if (pc_write) obs_pc++;
            if (mem_write) obs_memw++;
            if (jump) obs_jump++;
            if (imem_req) obs_imem++;
            if (reg_write && result_source == 2'b01) obs_resmem++;
            if (alu_control == 3'b011 && !reg_write && !dmem_req && !imem_req) obs_div++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_instret",  32'(instret),  32'd0);
        chk("rst_illegal",  32'(illegal),  32'd0);

        run_inst(KEY_ADD, 0, 0);
        chk("add_cycles", obs_cycles, 4);
        chk("add_reg_cnt", obs_reg, 1);
        chk("add_reg_at", obs_reg_at, 4);
        @(posedge clk); #1;
        chk("add_instret", 32'(instret), 32'd1);

        run_inst(KEY_LH, 0, 3);
        chk("lh_cycles", obs_cycles, 8);
        chk("lh_dmem_cnt", obs_dmem, 4);
        chk("lh_resmem", obs_resmem, 1);

        run_inst(KEY_DIV, 0, 0);
        chk("div_cycles", obs_cycles, 19);
        chk("div_alu011", obs_div, 16);
        chk("div_reg_at", obs_reg_at, 19);

        run_inst(KEY_BEQ, 0, 0);
        chk("beq_cycles", obs_cycles, 3);
        chk("beq_branch", obs_branch, 1);
        chk("beq_branch_at", obs_branch_at, 3);
        chk("beq_pc", obs_pc, 0);
        chk("beq_reg", obs_reg, 0);

        run_inst(KEY_SB, 2, 1);
        chk("sb_cycles", obs_cycles, 7);
        chk("sb_memw", obs_memw, 2);
        chk("sb_reg", obs_reg, 0);

        run_inst(KEY_JAL, 1, 0);
        chk("jal_jump", obs_jump, 1);

        run_inst(KEY_MUL, 0, 0);
        chk("mul_cycles", obs_cycles, 6);

        run_inst(KEY_JALR, 0, 0);
        run_inst(KEY_LUI, 0, 0);
        run_inst(KEY_SLL, 0, 0);
        run_inst(KEY_SLR, 1, 0);
        run_inst(KEY_SUB, 0, 0);
        run_inst(KEY_REMU, 0, 0);
        run_inst(KEY_ADDI, 0, 0);
        run_inst(KEY_LBU, 1, 0);
        run_inst(KEY_BLT, 0, 0);

        run_inst(KEY_BAD, 0, 0);
        build_halt(10);
        run_trace(1000);
        chk("halt_imem", obs_imem, 0);
        chk("halt_cycles", obs_cycles, 10);
        chk("halt_illegal", 32'(illegal), 32'd1);
        do_reset();
        #1;
        chk("post_halt_illegal", 32'(illegal), 32'd0);
        chk("post_halt_imem", 32'(imem_req), 32'd1);

        for (int k = 0; k < 16; k++) run_inst(KEY_ADD, 0, 0);
        @(posedge clk); #1;
        chk("wrap_instret", 32'(instret), 32'd0);

        run_inst(KEY_ADD, 0, 0);
        set_inst(KEY_MUL);
        build(KEY_MUL, 0, 0);
        run_trace(4);
        do_reset();
        #1;
        chk("mulrst_imem", 32'(imem_req), 32'd1);
        chk("mulrst_instret", 32'(instret), 32'd0);
        chk("mulrst_alu", 32'(alu_control), 32'd0);

        set_inst(KEY_LH);
        build(KEY_LH, 0, 5);
        run_trace(5);
        do_reset();
        #1;
        chk("memrst_imem", 32'(imem_req), 32'd1);
        chk("memrst_dmem", 32'(dmem_req), 32'd0);

        run_inst(KEY_ADD, 0, 0);
        chk("final_add_cycles", obs_cycles, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MUL_CYCLES, 3, EXEC cycles for MUL (>=1).
- DIV_CYCLES, 16, EXEC cycles for DIV and REMU (>=1).
- CNT_W, 32, retired-instruction counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- inst_type, in, 2, instruction-register type field.
- dir_mode, in, 2, addressing-mode field.
- opcode, in, 3, opcode field.
- imem_ready, in, 1, instruction memory completes request this cycle.
- dmem_ready, in, 1, data memory completes request this cycle.
- imem_req, out, 1, instruction fetch request.
- dmem_req, out, 1, data access request.
- ir_write, out, 1, load instruction register.
- pc_write, out, 1, unconditional PC update.
- reg_write, mem_write, branch, jump, out, 1 each, datapath strobes.
- result_source, out, 2: 00 ALU, 01 MEM, 10 PC+4.
- alu_source, out, 1: 0 REG, 1 IMM.
- alu_control, out, 3, ALU operation.
- illegal, out, 1, sticky illegal-instruction flag.
- instret, out, CNT_W, retired-instruction count.

Function
REQ-003 Decode key SHALL be {opcode, dir_mode, inst_type} (7 bits).
REQ-004 Decode classes SHALL be:
- dir_mode=00, type=00: R-ALU; opcode 0-4 = ADD/SUB/MUL/DIV/REMU; alu_control = opcode.
- dir_mode=01, type=00: I-ALU; opcode 0/1/2 = ADDI/SLL/SLR; alu_control 000/101/110.
- dir_mode=01, type=01: opcode 0 = SB; opcode 1-3 = loads (LBU/LHU/LH).
- dir_mode=01, type=10: opcode 0 = JALR; opcode 1-4 = BEQ/BNE/BLE/BLT, alu_control 001.
- key 0001000: LUI (alu_control 101).
- key 0001010: JAL.
- Any other key is illegal.
REQ-005 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-006 FETCH SHALL hold imem_req=1 until imem_ready; in the imem_ready cycle it SHALL assert ir_write=1 and go to DECODE.
REQ-007 DECODE SHALL last one cycle, latch the decode key internally, and go to EXEC, or to HALT if illegal.
REQ-008 EXEC length SHALL be MUL_CYCLES for MUL, DIV_CYCLES for DIV/REMU, else 1, using an internal down-counter.
- alu_source and alu_control SHALL be held for the whole EXEC duration.
REQ-009 After EXEC:
- loads/SB go to MEM;
- ALU, LUI, JAL, JALR go to WB;
- branches return to FETCH with branch=1 and pc_write=0 in their last EXEC cycle.
REQ-010 MEM SHALL hold dmem_req=1 until dmem_ready; SB SHALL assert mem_write=1 throughout MEM, then return to FETCH with pc_write=1 in the dmem_ready cycle; loads go to WB.
REQ-011 WB SHALL last one cycle and assert reg_write=1 and pc_write=1.
- result_source: 01 for loads, 10 for JAL/JALR, 00 otherwise.
- jump=1 for JAL/JALR.
REQ-012 The final cycle of every retired instruction SHALL increment instret by 1, wrapping modulo 2^CNT_W.
REQ-013 HALT SHALL be absorbing until reset; it SHALL set illegal=1 and drive all strobes 0.
REQ-014 Strobes not named for a state SHALL be 0 in that state; outputs SHALL be combinational from state and latched key.
REQ-015 mem_write and reg_write SHALL never be 1 in the same cycle.

Reset
REQ-016 While reset=1 at a clk edge:
- state SHALL become FETCH;
- the counter, latched key, instret and illegal SHALL clear.
REQ-017 Reset SHALL override any in-flight request, including mid-EXEC and mid-MEM; imem_req SHALL be 1 in the first cycle after reset.

Structure
REQ-018 Package isa_pkg SHALL hold:
- the state enum;
- decode-key constants;
- alu_control and result_source encodings.
REQ-019 Sub-module exec_cycle_counter (loadable down-counter, done flag) SHALL implement the EXEC timing.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- ADD, zero-wait memories: 4 cycles FETCH->WB; reg_write=1 only in cycle 4; instret 0->1.
- LH with dmem_ready delayed 3 cycles: dmem_req high 4 cycles, then WB with result_source=01; 8 cycles total.
- DIV with DIV_CYCLES=16: alu_control=011 held 16 EXEC cycles; reg_write in the following cycle.
- BEQ: 3 cycles; branch=1 only in cycle 3; pc_write never asserted; reg_write never asserted.
- Key 1110000: HALT reached after DECODE, illegal=1, imem_req=0 for 10 further cycles; reset then returns FETCH with illegal=0.
- CNT_W=4, 16 ADDs: instret wraps to 0; reset asserted mid-MUL forces FETCH next cycle.
